tdm_demux_1x8: RTL

- Time-division 1-to-8 demultiplexer: the receive-side counterpart of the 8:1 lane multiplexer.
- Accepts a serial bit stream, one bit per valid cycle. A 3-bit slot counter steers each bit into lane k of a word register.
- When all 8 slots are filled, the word is presented to downstream logic over a valid/ready handshake.
- Frame alignment comes from a start-of-frame marker.

---
 rtl/tdm_demux_1x8.sv | 108 ++++++++++
 1 files changed

// File: rtl/tdm_demux_1x8.sv
// ---------------------------------------------------------------------------
// tdm_demux_1x8
// Time-division 1-to-8 demultiplexer. A serial bit stream, one bit per
// valid cycle, is steered by a slot counter into a word register. Each
// completed word is offered downstream over a valid/ready handshake.
// Frame alignment is acquired and re-acquired from a start-of-frame marker.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   din          serial data bit
//   din_valid    din is valid this cycle
//   sof          start of frame (qualified by din_valid), din is slot 0
//   word_out     demultiplexed word, bit k = bit received in slot k
//   word_valid   word_out holds an unconsumed frame
//   word_ready   downstream accepts word_out when word_valid is high
//   slot         slot the next valid bit will be written to
//   locked       high while collecting aligned frames
//   overrun      sticky flag: a completed frame was dropped
//   clr_overrun  clears overrun (a simultaneous new drop wins)
// ---------------------------------------------------------------------------
module tdm_demux_1x8 #(
  parameter int LANES = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [LANES-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

  logic [0:0]       state;
  logic [LANES-1:0] shift;
  logic             frame_done;
  logic             buf_free;
  logic             drain;

  // A frame completes only on a non-sof bit landing in the last slot while
  // collecting; a sof bit always restarts at slot 0, so it can never finish
  // a frame. The output buffer can take a new word if it is empty or is
  // being drained in this very cycle, which avoids a bubble between frames.
  always_comb begin
    frame_done = din_valid && !sof && (state == COLLECT) && (slot == LAST_SLOT);
    drain      = word_valid && word_ready;
    buf_free   = !word_valid || word_ready;
  end

  // Alignment FSM, slot counter and shift register. A sof restarts the frame
  // from either state; earlier partial bits are left in place because every
  // slot above 0 is rewritten before the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      slot  <= '0;
      shift <= '0;
    end else if (din_valid) begin
      if (sof) begin
        shift[0] <= din;
        slot     <= SEL_W'(1);
        state    <= COLLECT;
      end else if (state == COLLECT) begin
        shift[slot] <= din;
        slot        <= (slot == LAST_SLOT) ? '0 : slot + SEL_W'(1);
      end
    end
  end

  // Output buffer. The last bit bypasses the shift register so the word is
  // available one cycle after its final bit is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (frame_done && buf_free) begin
      word_out   <= {din, shift[LANES-2:0]};
      word_valid <= 1'b1;
    end else if (drain) begin
      word_valid <= 1'b0;
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear must still be seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (frame_done && !buf_free) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign locked = (state == COLLECT);

endmodule
